// File: rtl/mips_div_pkg.sv
// Shared types and sizing for the sequential MIPS divider.
package mips_div_pkg;
  localparam int DIV_N     = 32;
  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step; the borrow out of the subtraction selects the quotient bit.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_i,
  input  logic         bit_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   r_next_o,
  output logic         qbit_o
);
  logic [N+1:0] sub;

  // r_i[N] is always 0 between steps, so sub[N+1] is exactly the borrow.
  assign sub      = {r_i, bit_i} - {2'b00, dvs_i};
  assign qbit_o   = ~sub[N+1];
  assign r_next_o = sub[N+1] ? {r_i[N-1:0], bit_i} : sub[N:0];
endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division over N steps, then a sign-fix cycle.
module mips_seq_divider
  import mips_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);

  div_state_e   state_q;
  logic [N:0]   r_q, r_d;
  logic [N-1:0] q_q, dvs_q, q_d;
  logic [CW-1:0] cnt_q;
  logic         qneg_q, rneg_q, dz_q, qbit;
  logic         done_q, dbz_q;
  logic [N-1:0] quot_q, rem_q;
  logic [N-1:0] dvd_mag, dvs_mag;

  assign dvd_mag = (is_signed & dividend[N-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed & divisor[N-1])  ? -divisor  : divisor;

  div_step #(.N(N)) u_step (
    .r_i      (r_q),
    .bit_i    (q_q[N-1]),
    .dvs_i    (dvs_q),
    .r_next_o (r_d),
    .qbit_o   (qbit)
  );

  assign q_d = {q_q[N-2:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          r_q    <= '0;
          dvs_q  <= dvs_mag;
          cnt_q  <= CW'(N);
          qneg_q <= is_signed & (dividend[N-1] ^ divisor[N-1]);
          rneg_q <= is_signed & dividend[N-1];
          dz_q   <= (divisor == '0);
          // On divide-by-zero Q carries the raw dividend through to HI.
          q_q    <= (divisor == '0) ? dividend : dvd_mag;
          state_q <= (divisor == '0) ? FIX : RUN;
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            quot_q <= '1;
            rem_q  <= q_q;
            dbz_q  <= 1'b1;
          end else begin
            quot_q <= qneg_q ? -q_q : q_q;
            rem_q  <= rneg_q ? -r_q[N-1:0] : r_q[N-1:0];
            dbz_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed bench for mips_seq_divider with a cycle-level arithmetic reference model.
module tb_mips_seq_divider;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  mips_seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference result {dz, q, r} from plain integer arithmetic.
  function automatic logic [2*N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
    longint sa, sb;
    logic [N-1:0] q, r;
    if (b == '0) return {1'b1, {N{1'b1}}, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = N'(sa / sb);
      r  = N'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Model: remaining cycles until done, and the pending result.
  int           m_cnt = 0;
  logic         m_done = 1'b0, m_dz = 1'b0;
  logic [N-1:0] m_q = '0, m_r = '0;
  logic [2*N:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_pend <= ref_div(dividend, divisor, is_signed);
          m_cnt  <= (divisor == '0) ? 1 : N + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          {m_dz, m_q, m_r} <= m_pend;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("m_busy", N'(busy), N'(m_cnt != 0));
    chk("m_done", N'(done), N'(m_done));
    chk("m_quot", quotient, m_q);
    chk("m_rem", remainder, m_r);
    chk("m_dz", N'(div_by_zero), N'(m_dz));
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                        input int elat);
    int cyc, nb;
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 'x; divisor = 'x; is_signed = ~s;
    cyc = 1; nb = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", N'(cyc), N'(elat));
    chk("busy_cycles", N'(nb), N'(elat - 1));
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", N'(div_by_zero), N'(edz));
    @(negedge clk);
    chk("done_pulse", N'(done), '0);
    dividend = '0; divisor = '0; is_signed = 1'b0;
  endtask

  initial begin
    int cyc, nd, cons;
    logic pd;
    repeat (3) @(negedge clk);
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    chk("rst_quot", quotient, '0);
    chk("rst_rem", remainder, '0);
    chk("rst_dz", N'(div_by_zero), '0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);

    // Second start mid-RUN must be dropped, not queued.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ign_done", N'(done), N'(1));
    chk("ign_quot", quotient, 32'd14);
    chk("ign_rem", remainder, 32'd2);
    @(negedge clk);
    chk("ign_not_queued", N'(busy), '0);

    // Reset at step 10 aborts silently.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", N'(busy), '0);
    chk("abort_quot", quotient, '0);
    chk("abort_rem", remainder, '0);
    chk("abort_dz", N'(div_by_zero), '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", N'(done), '0);
    end
    rst_n = 1'b1;
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);

    // Start held high: back-to-back ops, each done exactly one cycle.
    @(negedge clk);
    dividend = 32'd20; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    nd = 0; cons = 0; pd = 1'b0;
    repeat (3 * (N + 2)) begin
      @(negedge clk);
      if (done) nd++;
      if (done && pd) cons++;
      pd = done;
    end
    start = 1'b0;
    chk("b2b_dones", N'(nd), N'(3));
    chk("b2b_single", N'(cons), '0);
    chk("b2b_quot", quotient, 32'd6);
    chk("b2b_rem", remainder, 32'd2);
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b2b_idle", N'(busy), '0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
